// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data requester, external bus and status signals of the memory port arbiter
// Optional statistics signals exist only when MEM_ARB_STATS_EN is defined.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_gnt;
   logic              if_done;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_done;
   logic [DATA_W-1:0] dm_rdata;

   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_ack;
   logic              bus_rvalid;
   logic [DATA_W-1:0] bus_rdata;

   logic              busy;

`ifdef MEM_ARB_STATS_EN
   logic [31:0]       stat_if_grants;
   logic [31:0]       stat_dm_grants;
`endif

   // Arbiter side
   modport slave (
      input  if_req, if_addr, if_flush,
      output if_gnt, if_done, if_rdata,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      output dm_gnt, dm_done, dm_rdata,
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_ack, bus_rvalid, bus_rdata,
`ifdef MEM_ARB_STATS_EN
      output stat_if_grants, stat_dm_grants,
`endif
      output busy
   );

   // Pipeline and memory side
   modport master (
      output if_req, if_addr, if_flush,
      input  if_gnt, if_done, if_rdata,
      output dm_req, dm_we, dm_addr, dm_wdata,
      input  dm_gnt, dm_done, dm_rdata,
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_ack, bus_rvalid, bus_rdata,
`ifdef MEM_ARB_STATS_EN
      input  stat_if_grants, stat_dm_grants,
`endif
      input  busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one external memory port between instruction fetch and the data stage
// Optional grant counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter #(
   parameter int ADDR_W        = 64,
   parameter int DATA_W        = 64,
   parameter int MAX_DM_STREAK = 4
) (
   input logic              clk,
   input logic              reset,
   mem_port_arbiter_if.slave mp
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

   state_t     state;
   owner_t     owner;
   logic [3:0] dm_streak;
   logic       flush_seen;

   logic       if_cand;
   logic       pick_if;
   logic       pick_dm;

   // Arbitration: a flushed fetch never competes; DM wins unless its streak has reached the limit
   always_comb begin
      if_cand = mp.if_req && !mp.if_flush;
      pick_if = if_cand && (!mp.dm_req || dm_streak == STREAK_MAX);
      pick_dm = mp.dm_req && !pick_if;
   end

   // Transaction FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= OWN_NONE;
         dm_streak  <= '0;
         flush_seen <= 1'b0;
         mp.if_gnt    <= 1'b0;
         mp.if_done   <= 1'b0;
         mp.if_rdata  <= '0;
         mp.dm_gnt    <= 1'b0;
         mp.dm_done   <= 1'b0;
         mp.dm_rdata  <= '0;
         mp.bus_req   <= 1'b0;
         mp.bus_we    <= 1'b0;
         mp.bus_addr  <= '0;
         mp.bus_wdata <= '0;
         mp.busy      <= 1'b0;
      end else begin
         mp.if_gnt  <= 1'b0;
         mp.dm_gnt  <= 1'b0;
         mp.if_done <= 1'b0;
         mp.dm_done <= 1'b0;
         case (state)
            IDLE: begin
               flush_seen <= 1'b0;
               if (pick_if) begin
                  owner        <= OWN_IF;
                  mp.if_gnt    <= 1'b1;
                  mp.bus_req   <= 1'b1;
                  mp.bus_we    <= 1'b0;
                  mp.bus_addr  <= mp.if_addr;
                  mp.bus_wdata <= '0;
                  dm_streak    <= '0;
                  mp.busy      <= 1'b1;
                  state        <= ISSUE;
               end else if (pick_dm) begin
                  owner        <= OWN_DM;
                  mp.dm_gnt    <= 1'b1;
                  mp.bus_req   <= 1'b1;
                  mp.bus_we    <= mp.dm_we;
                  mp.bus_addr  <= mp.dm_addr;
                  mp.bus_wdata <= mp.dm_wdata;
                  mp.busy      <= 1'b1;
                  state        <= ISSUE;
                  if (!if_cand)
                     dm_streak <= '0;
                  else if (dm_streak != STREAK_MAX)
                     dm_streak <= dm_streak + 4'd1;
               end
            end
            ISSUE: begin
               if (owner == OWN_IF && mp.if_flush)
                  flush_seen <= 1'b1;
               // A read response in the ack cycle is too early and is dropped
               if (mp.bus_ack) begin
                  mp.bus_req <= 1'b0;
                  if (mp.bus_we) begin
                     mp.dm_done <= 1'b1;
                     mp.busy    <= 1'b0;
                     owner      <= OWN_NONE;
                     state      <= IDLE;
                  end else begin
                     state <= WAIT_RESP;
                  end
               end
            end
            WAIT_RESP: begin
               if (owner == OWN_IF && mp.if_flush)
                  flush_seen <= 1'b1;
               if (mp.bus_rvalid) begin
                  if (owner == OWN_DM) begin
                     mp.dm_rdata <= mp.bus_rdata;
                     mp.dm_done  <= 1'b1;
                  end else if (!(flush_seen || mp.if_flush)) begin
                     mp.if_rdata <= mp.bus_rdata;
                     mp.if_done  <= 1'b1;
                  end
                  mp.busy <= 1'b0;
                  owner   <= OWN_NONE;
                  state   <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               owner   <= OWN_NONE;
               mp.busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef MEM_ARB_STATS_EN
   // Saturating grant counters, stepped on the same edge that raises each gnt
   always_ff @(posedge clk) begin
      if (reset) begin
         mp.stat_if_grants <= '0;
         mp.stat_dm_grants <= '0;
      end else if (state == IDLE) begin
         if (pick_if && mp.stat_if_grants != 32'hFFFF_FFFF)
            mp.stat_if_grants <= mp.stat_if_grants + 32'd1;
         if (pick_dm && mp.stat_dm_grants != 32'hFFFF_FFFF)
            mp.stat_dm_grants <= mp.stat_dm_grants + 32'd1;
      end
   end
`endif

endmodule
